// File: rtl/signed_mul_seq.sv
// Sequential radix-2 Booth signed multiplier with a start/busy/done handshake.
// Optional fused addend (product = A*B + addend) is enabled by defining MUL_ADDEND_EN.
module signed_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     addend,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   b_shift;
  logic               q_m1;
  logic [CW-1:0]      count;

  logic [WIDTH:0]     ext_a;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     acc_next;
  logic [WIDTH-1:0]   b_next;
  logic               q_next;
  logic [2*WIDTH-1:0] raw;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH:0]     result_top;
  logic               result_ovf;

`ifdef MUL_ADDEND_EN
  logic [WIDTH-1:0]   addend_reg;
`else
  logic               unused_addend;
  assign unused_addend = ^addend;
`endif

  // acc carries one guard bit so that subtracting -2^(WIDTH-1) cannot wrap
  assign ext_a = {a_reg[WIDTH-1], a_reg};

  always_comb begin
    sum = acc;
    case ({b_shift[0], q_m1})
      2'b01:   sum = acc + ext_a;
      2'b10:   sum = acc - ext_a;
      default: sum = acc;
    endcase
  end

  // Arithmetic right shift of the whole {acc, b_shift, q_m1} register
  assign acc_next = {sum[WIDTH], sum[WIDTH:1]};
  assign b_next   = {sum[0], b_shift[WIDTH-1:1]};
  assign q_next   = b_shift[0];
  assign raw      = {acc_next[WIDTH-1:0], b_next};

  always_comb begin
`ifdef MUL_ADDEND_EN
    result = raw + {{WIDTH{addend_reg[WIDTH-1]}}, addend_reg};
`else
    result = raw;
`endif
  end

  assign result_top = result[2*WIDTH-1:WIDTH-1];
  assign result_ovf = ~((&result_top) | ~(|result_top));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      acc     <= '0;
      b_shift <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      ovf     <= 1'b0;
`ifdef MUL_ADDEND_EN
      addend_reg <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg   <= multiplicand;
            b_shift <= multiplier;
            acc     <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
`ifdef MUL_ADDEND_EN
            addend_reg <= addend;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc     <= acc_next;
          b_shift <= b_next;
          q_m1    <= q_next;
          if (count == LAST) begin
            product <= result;
            ovf     <= result_ovf;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_mul_seq.sv
// Scoreboard bench for signed_mul_seq: stimulus pushes expected results,
// a monitor pops and compares whenever done is presented.
module tb_signed_mul_seq;
  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [W-1:0]   addend;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic           ovf;

  int checks = 0;
  int errors = 0;
  int busy_cnt;
  logic prev_done = 1'b0;
  logic [2*W:0] sb[$];

  signed_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier), .addend(addend),
    .busy(busy), .done(done), .product(product), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: exact integer product (plus addend), overflow by range test
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] ad);
    longint p;
    logic o;
    p = longint'($signed(a)) * longint'($signed(b));
`ifdef MUL_ADDEND_EN
    p = p + longint'($signed(ad));
`endif
    o = (p > longint'(2 ** (W - 1) - 1)) || (p < -longint'(2 ** (W - 1)));
    return {o, p[2*W-1:0]};
  endfunction

  // Monitor: compare each presented result against the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      if (done && prev_done)
        check(1'b0, "done_single_cycle", 1, 0);
      if (done) begin
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_done", 1, 0);
        end else begin
          logic [2*W:0] exp;
          exp = sb.pop_front();
          check(product == exp[2*W-1:0], "product", longint'(product), longint'(exp[2*W-1:0]));
          check(ovf == exp[2*W], "ovf", longint'(ovf), longint'(exp[2*W]));
        end
      end
    end
    prev_done = done;
  end

  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] ad);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    addend       = ad;
    start        = 1'b1;
    sb.push_back(model(a, b, ad));
    @(posedge clk);
    #1;
    start        = 1'b0;
    busy_cnt     = busy ? 1 : 0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    addend       = W'($urandom);
  endtask

  task automatic check_output();
    int edges = 0;
    while (!done && edges < W + 8) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_cnt++;
    end
    check(edges == W, "latency_edges", longint'(edges), longint'(W));
    check(busy_cnt == W, "busy_cycles", longint'(busy_cnt), longint'(W));
  endtask

  task automatic wait_idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] va [6];
    int spacing;
    int edges;

    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    addend = '0;
    rst_n = 1'b0;
    #1;
    check(busy == 1'b0, "reset_busy", longint'(busy), 0);
    check(done == 1'b0, "reset_done", longint'(done), 0);
    check(product == '0, "reset_product", longint'(product), 0);
    check(ovf == 1'b0, "reset_ovf", longint'(ovf), 0);
    #22;
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed products");
    apply_stimulus(16'd3, -16'sd7, 16'd0);
    check_output();
    apply_stimulus(16'h8000, 16'h8000, 16'd0);
    check_output();
    apply_stimulus(16'h8000, 16'h0001, 16'd0);
    check_output();
    apply_stimulus(16'h0000, 16'h1234, 16'd0);
    check_output();
    apply_stimulus(16'h8001, 16'h0000, 16'd0);
    check_output();
    apply_stimulus(16'h7FFF, 16'h7FFF, 16'd0);
    check_output();
    apply_stimulus(16'h7FFF, 16'h8000, 16'd0);
    check_output();
    apply_stimulus(-16'sd3, 16'd7, -16'sd2);
    check_output();
    wait_idle(3);

    $display("[TB] start during RUN is ignored");
    apply_stimulus(16'd100, 16'd200, 16'd0);
    wait_idle(4);
    @(negedge clk);
    start = 1'b1;
    multiplicand = 16'd1;
    multiplier = 16'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 0;
    while (!done && edges < W + 8) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check(edges == W - 5, "ignore_latency", longint'(edges), longint'(W - 5));
    wait_idle(W + 4);

    $display("[TB] reset mid-operation");
    apply_stimulus(-16'sd5, 16'd9, 16'd0);
    wait_idle(7);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check(busy == 1'b0, "abort_busy", longint'(busy), 0);
    check(done == 1'b0, "abort_done", longint'(done), 0);
    check(product == '0, "abort_product", longint'(product), 0);
    check(ovf == 1'b0, "abort_ovf", longint'(ovf), 0);
    wait_idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(W + 4);
    apply_stimulus(16'd2, 16'd2, 16'd0);
    check_output();
    wait_idle(2);

    $display("[TB] back-to-back with start held");
    @(negedge clk);
    multiplicand = 16'hFFFF;
    multiplier = 16'hFFFF;
    start = 1'b1;
    sb.push_back(model(16'hFFFF, 16'hFFFF, 16'd0));
    @(posedge clk);
    #1;
    multiplicand = 16'd12;
    multiplier = -16'sd12;
    sb.push_back(model(16'd12, -16'sd12, 16'd0));
    edges = 0;
    while (!done && edges < W + 8) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check(edges == W, "b2b_first_latency", longint'(edges), longint'(W));
    spacing = 0;
    do begin
      @(posedge clk);
      #1;
      start = 1'b0;
      spacing++;
    end while (!done && spacing < W + 8);
    check(spacing == W + 1, "b2b_spacing", longint'(spacing), longint'(W + 1));
    wait_idle(2);

    $display("[TB] randomized operands");
    va[0] = 16'h8000; va[1] = 16'h7FFF; va[2] = 16'h0000;
    va[3] = 16'h0001; va[4] = 16'hFFFF; va[5] = 16'h8001;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b, ad;
      a  = (i % 4 == 0) ? va[$urandom_range(0, 5)] : W'($urandom);
      b  = (i % 3 == 0) ? va[$urandom_range(0, 5)] : W'($urandom);
      ad = (i % 5 == 0) ? va[$urandom_range(0, 5)] : W'($urandom);
      apply_stimulus(a, b, ad);
      check_output();
    end
    wait_idle(W + 4);

    check(sb.size() == 0, "scoreboard_drained", longint'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
